// File: rtl/time_display_pkg.sv
// Shared types and constants for the countdown display: converter states,
// 7-segment code table and BCD helpers.
// Latency: n/a (declarations only). Backpressure: n/a.
package time_display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BIN_W      = 14;
    localparam int SAT_MAX    = 9999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    // Active-low segment codes {g,f,e,d,c,b,a}; index 9 is the leftmost entry.
    localparam logic [9:0][6:0] SEG_CODES = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Double-dabble correction: add 3 to every nibble that is 5 or more, so
    // the following left shift carries correctly into the next decade.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Recovers the binary value of a 4-digit BCD word.
    function automatic logic [BIN_W-1:0] bcd_to_bin(input logic [15:0] b);
        int v;
        v = int'(b[15:12]) * 1000 + int'(b[11:8]) * 100
          + int'(b[7:4]) * 10 + int'(b[3:0]);
        return BIN_W'(v);
    endfunction

endpackage

// File: rtl/time_display_seg7_decode.sv
// BCD digit to active-low 7-segment decoder; codes 10..15 turn all segments off.
// Latency: combinational. Backpressure: none.
// Ports: i_bcd (4-bit digit in), o_seg (7-bit {g,f,e,d,c,b,a}, active low).
module seg7_decode
    import time_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        if (i_bcd <= 4'd9) begin
            o_seg = SEG_CODES[i_bcd];
        end
    end

endmodule

// File: rtl/time_display.sv
// Countdown display: clamps time_left to 0..9999, converts it to BCD by a
// continuously repeating 16-cycle double-dabble FSM and multiplexes it onto a
// 4-digit active-low 7-segment display with leading-zero blanking.
// Latency: bcd_out/conv_done update on the 16th edge after the IDLE sample.
// Backpressure: none; free-running, input sampled once per conversion.
// Ports: clock, reset (async active low), time_left[31:0] (signed seconds),
//        bcd_out[15:0], conv_done (1-cycle pulse), seg[6:0], an[3:0].
// Optional: define TIME_DISPLAY_BLINK_EN to blank the display on alternate
//           BLINK_DIV-cycle phases while the shown value is 1..BLINK_THRESH.
module time_display
    import time_display_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_DIV    = 25000000,
    parameter int BLINK_THRESH = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] time_left,
    output logic [15:0] bcd_out,
    output logic        conv_done,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    if (SCAN_DIV < 2 || SCAN_DIV > (1 << 20) || BLINK_DIV < 2 || BLINK_THRESH < 0) begin : g_bad_param
        $error("time_display: parameter out of range");
    end

    // Input conditioning: negative -> 0, above 9999 -> 9999.
    logic [BIN_W-1:0] w_cond;
    always_comb begin
        if (time_left[31]) begin
            w_cond = '0;
        end else if (time_left[30:0] > 31'(SAT_MAX)) begin
            w_cond = BIN_W'(SAT_MAX);
        end else begin
            w_cond = time_left[BIN_W-1:0];
        end
    end

    // Converter: 1 IDLE + 14 SHIFT + 1 DONE = 16 cycles per conversion.
    conv_state_t      r_state;
    logic [BIN_W-1:0] r_bin;
    logic [15:0]      r_acc;
    logic [3:0]       r_cnt;
    logic [15:0]      r_bcd;
    logic             r_done;
    logic [15:0]      w_adj;

    assign w_adj = bcd_adjust(r_acc);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_bin   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_bin   <= w_cond;
                    r_acc   <= '0;
                    r_cnt   <= 4'(BIN_W);
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_acc <= (w_adj << 1) | {15'b0, r_bin[BIN_W-1]};
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_bcd   <= r_acc;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bcd_out   = r_bcd;
    assign conv_done = r_done;

    // Digit scan.
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [1:0]        r_digit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_scan_cnt <= '0;
            r_digit    <= '0;
        end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_digit    <= r_digit + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    // A digit is a leading zero when it and every digit above it are zero;
    // digit 0 always shows so that zero reads "0".
    logic       w_blank;
    logic       w_blink_off;
    logic [3:0] w_nib;

    assign w_blank = (r_digit != 2'd0) && ((bcd_out >> {r_digit, 2'b00}) == 16'h0);
    assign w_nib   = bcd_out[{r_digit, 2'b00} +: 4];

`ifdef TIME_DISPLAY_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV);

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic [BIN_W-1:0]   w_disp_val;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
    end

    // Zero is held steady; only small non-zero values blink.
    assign w_disp_val  = bcd_to_bin(bcd_out);
    assign w_blink_off = r_blink_phase && (w_disp_val != '0)
                       && (int'(w_disp_val) <= BLINK_THRESH);
`else
    assign w_blink_off = 1'b0;
`endif

    assign an = (w_blank || w_blink_off) ? 4'hF : ~(4'b0001 << r_digit);

    seg7_decode u_seg7_decode (
        .i_bcd (w_nib),
        .o_seg (seg)
    );

endmodule

// File: tb/tb_time_display.sv
// Self-checking bench for time_display (SCAN_DIV=4, BLINK_DIV=8).
// A posedge model pushes the clamped input at each expected sampling edge;
// the negedge monitor pops on each expected conv_done and checks an/seg.
module tb_time_display;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] time_left = 32'd1234;
    logic [15:0] bcd_out;
    logic        conv_done;
    logic [6:0]  seg;
    logic [3:0]  an;

    time_display #(.SCAN_DIV(4), .BLINK_DIV(8), .BLINK_THRESH(10)) dut (
        .clock     (clock),
        .reset     (reset),
        .time_left (time_left),
        .bcd_out   (bcd_out),
        .conv_done (conv_done),
        .seg       (seg),
        .an        (an)
    );

    always #5 clock = ~clock;

    localparam logic [6:0] SEG_REF [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_q[$];
    int model_disp = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input logic [31:0] v);
        if (v[31]) return 0;
        if (v > 32'd9999) return 9999;
        return int'(v);
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Edge counter since reset release; edges 1, 17, 33, ... sample the input.
    always @(posedge clock) begin
        if (!reset) begin
            cyc = 0;
            exp_q.delete();
        end else begin
            cyc++;
            if ((cyc - 1) % 16 == 0) exp_q.push_back(clamp(time_left));
        end
    end

    logic        m_exp_done;
    logic [15:0] m_bcd;
    int          m_dig;
    int          m_hi;
    logic        m_blank;
    logic        m_blink;
    logic [3:0]  m_exp_an;
    logic [3:0]  m_nib;

    always @(negedge clock) begin
        if (!reset) begin
            model_disp = 0;
        end else begin
            m_exp_done = (cyc != 0) && (cyc % 16 == 0);
            if (m_exp_done || conv_done) begin
                check("conv_done", {31'b0, conv_done}, {31'b0, m_exp_done});
                if (m_exp_done) begin
                    check("sb_nonempty", exp_q.size(), (exp_q.size() == 0) ? 1 : exp_q.size());
                    if (exp_q.size() != 0) begin
                        model_disp = exp_q.pop_front();
                        check("bcd_out", {16'b0, bcd_out}, {16'b0, to_bcd(model_disp)});
                    end
                end
            end
            m_bcd = to_bcd(model_disp);
            m_dig = (cyc / 4) % 4;
            m_hi  = 0;
            for (int i = 0; i < 4; i++) begin
                if (((m_bcd >> (i * 4)) & 16'hF) != 16'h0) m_hi = i;
            end
            m_blank = (m_dig > m_hi);
`ifdef TIME_DISPLAY_BLINK_EN
            m_blink = (model_disp >= 1) && (model_disp <= 10) && (((cyc / 8) % 2) == 1);
`else
            m_blink = 1'b0;
`endif
            m_exp_an = (m_blank || m_blink) ? 4'hF : ~(4'b0001 << m_dig);
            check("an", {28'b0, an}, {28'b0, m_exp_an});
            if (m_exp_an != 4'hF) begin
                m_nib = 4'((m_bcd >> (m_dig * 4)) & 16'hF);
                check("seg", {25'b0, seg}, {25'b0, SEG_REF[m_nib]});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wait_phase(input int ph);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (cyc % 16 == ph) found = 1'b1;
            else step(1);
        end
        check("wait_phase", {31'b0, found}, 32'd1);
    endtask

    logic [31:0] stim [0:6];

    initial begin
        stim[0] = 32'hFFFF_FFF6;
        stim[1] = 32'd12000;
        stim[2] = 32'd9999;
        stim[3] = 32'd0;
        stim[4] = 32'd10;
        stim[5] = 32'd11;
        stim[6] = 32'd7;

        repeat (2) @(posedge clock);
        #1;
        check("rst_bcd",  {16'b0, bcd_out}, 32'h0);
        check("rst_done", {31'b0, conv_done}, 32'h0);
        check("rst_an",   {28'b0, an}, 32'hE);
        check("rst_seg",  {25'b0, seg}, 32'h40);

        @(posedge clock);
        #2;
        reset = 1'b1;
        step(40);

        for (int k = 0; k < 7; k++) begin
            time_left = stim[k];
            step((k == 6) ? 64 : 48);
        end

        // Input change in the middle of SHIFT must wait for the next sample.
        wait_phase(0);
        time_left = 32'd1234;
        step(5);
        time_left = 32'd5678;
        step(40);

        // Reset in the middle of SHIFT.
        wait_phase(6);
        reset = 1'b0;
        #1;
        check("rst2_bcd",  {16'b0, bcd_out}, 32'h0);
        check("rst2_done", {31'b0, conv_done}, 32'h0);
        check("rst2_an",   {28'b0, an}, 32'hE);
        check("rst2_seg",  {25'b0, seg}, 32'h40);
        step(3);
        reset = 1'b1;
        step(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/time_display.md
TIME_DISPLAY -- requirements
Module: time_display

Interface
REQ-001 Parameter SCAN_DIV, default 50000, gives the clock cycles each digit is driven, range 2..2^20.
REQ-002 Parameter BLINK_DIV, default 25000000, gives the clock cycles per blink half-period; used only with the macro in REQ-021.
REQ-003 Parameter BLINK_THRESH, default 10, gives the displayed value at or below which blinking applies.
REQ-004 Port clock, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port time_left, input, 32 bits: the signed seconds-remaining value from the regfile timeLeft output.
REQ-007 Port bcd_out, output, 16 bits: the last converted value as 4 BCD digits, digit 3 most significant.
REQ-008 Port conv_done, output, 1 bit: one-cycle pulse when bcd_out updates.
REQ-009 Port seg, output, 7 bits: active-low segments, ordered {g,f,e,d,c,b,a}.
REQ-010 Port an, output, 4 bits: active-low digit enables; an[0] drives the least significant digit.

Function
REQ-011 Input conditioning shall clamp the value: time_left[31]=1 shall give 0, values above 9999 shall give 9999, and all other values pass as 14-bit binary.
REQ-012 The converter FSM shall have the states IDLE, SHIFT and DONE.
- IDLE: capture the conditioned value, clear the BCD accumulator, load shift count 14, go to SHIFT.
- SHIFT: add 3 to each BCD nibble that is at least 5, shift left 1 with the next MSB of the binary, decrement the count, go to DONE after the 14th shift.
- DONE: load bcd_out, pulse conv_done, go to IDLE.
REQ-013 Conversion shall repeat continuously, with 16 cycles from one IDLE sampling edge to the next.
REQ-014 bcd_out and conv_done shall update on the 16th rising edge, counting the sampling edge as the 1st.
REQ-015 A change in time_left during SHIFT shall not affect the conversion in progress; the new value is taken at the next IDLE.
REQ-016 The scan counter shall count 0..SCAN_DIV-1 and wrap; at each wrap the digit index shall advance 0,1,2,3,0 (mod 4).
REQ-017 an shall be one-hot low for the current digit index.
REQ-018 seg shall be the 7-segment code of the bcd_out nibble for that digit, decoded from bcd_out and not from the converter accumulator.
REQ-019 Leading-zero blanking: any digit above the highest non-zero digit shall drive an=1111 in its slot; digit 0 is never blanked, so 0 displays as "0".
REQ-020 BCD nibbles 10..15 cannot occur; if forced, seg shall be all-off (7'h7F).

Configuration
REQ-021 With TIME_DISPLAY_BLINK_EN defined:
- A blink counter counts 0..BLINK_DIV-1 and toggles a phase bit at each wrap.
- When the displayed value is 1..BLINK_THRESH and the phase is 1, an shall be 1111.
- Value 0 shall be shown steadily.
REQ-022 Without TIME_DISPLAY_BLINK_EN, the blink counter shall not exist and an shall never be suppressed by blinking.

Reset
REQ-023 While reset=0, all outputs and state shall take these values:
- FSM in IDLE, bcd_out=16'h0000, conv_done=0.
- Scan counter and digit index 0, an=4'b1110, seg=7'h40 (digit "0").
- Blink counter and phase 0.
REQ-024 If reset asserts mid-conversion, the partial result shall be discarded; after release the first conv_done occurs on the 16th edge.

Structure
REQ-025 A shared package shall hold the FSM state enum, the segment code table for 0..9, and the constants NUM_DIGITS=4, BIN_W=14 and SAT_MAX=9999.
REQ-026 One sub-module, seg7_decode (4-bit BCD in, 7-bit active-low seg out, combinational), shall be instantiated once.

Verification
REQ-027 Directed scenarios, all with SCAN_DIV=4 and BLINK_DIV=8:
- Reset released, time_left=1234: conv_done on the 16th edge, bcd_out=16'h1234, an sequence 1110,1101,1011,0111 each for 4 cycles.
- time_left=32'hFFFFFFF6 (-10): bcd_out=16'h0000, only an[0] is ever driven low, and seg=7'h40.
- time_left=12000: bcd_out=16'h9999.
- time_left=7, macro defined: an=1111 for 8 cycles, then active for 8 cycles, repeating. Macro undefined: never 1111.
- time_left changed 1234→5678 mid-SHIFT: the next conv_done gives 16'h1234 and the following one gives 16'h5678.
- reset pulsed low during SHIFT: outputs return immediately to the REQ-023 values, and the first conv_done comes 16 edges after release.
